// File: rtl/normalizer_quantizer_if.sv
// normalizer_quantizer_if: Avalon-MM master bus between the quantizer and memory
interface normalizer_quantizer_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] writedata;
  logic        waitrequest;
  logic        readdatavalid;
  logic [31:0] readdata;
  modport master (output read, write, address, writedata, input waitrequest, readdatavalid, readdata);
  modport slave (input read, write, address, writedata, output waitrequest, readdatavalid, readdata);
endinterface

// File: rtl/normalizer_quantizer.sv
// normalizer_quantizer: reads 16-bit sample pairs, quantizes them to bytes and writes packed words
module normalizer_quantizer #(
  parameter int MAX_WORDS = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [31:0]            src_start_addr_i,
  input  logic [31:0]            src_stop_addr_i,
  input  logic [31:0]            dst_addr_i,
  input  logic [3:0]             shift_i,
  output logic                   busy_o,
  output logic                   irq_o,
  normalizer_quantizer_if.master avm
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, DONE} state_t;
  state_t        state_q, state_d;
  logic [31:0]   src_q, src_d, dst_q, dst_d, pack_q, pack_d;
  logic [CW-1:0] remain_q, remain_d, n_words;
  logic [3:0]    shift_q, shift_d;
  logic          half_q, half_d, irq_q, irq_d;
  logic [29:0]   span;
  logic [7:0]    q_lo, q_hi;

  function automatic logic [7:0] quant(input logic [15:0] s, input logic [3:0] sh);
    logic [15:0] v;
    v = s >> sh;
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

  assign span    = src_stop_addr_i[31:2] - src_start_addr_i[31:2];
  assign n_words = (src_stop_addr_i[31:2] <= src_start_addr_i[31:2]) ? '0 :
                   (span > 30'(MAX_WORDS)) ? CW'(MAX_WORDS) : span[CW-1:0];
  assign q_lo    = quant(avm.readdata[15:0], shift_q);
  assign q_hi    = quant(avm.readdata[31:16], shift_q);

  assign avm.read      = state_q == RD_REQ;
  assign avm.write     = state_q == WR;
  assign avm.address   = avm.read ? src_q : avm.write ? dst_q : '0;
  assign avm.writedata = avm.write ? pack_q : '0;
  assign busy_o        = state_q inside {RD_REQ, RD_WAIT, WR};
  assign irq_o         = irq_q || state_q == DONE;

  // next-state: one read in flight, two source words per packed write
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    pack_d   = pack_q;
    remain_d = remain_q;
    shift_d  = shift_q;
    half_d   = half_q;
    irq_d    = irq_q;
    case (state_q)
      IDLE: if (start_i) begin
        src_d    = {src_start_addr_i[31:2], 2'b00};
        dst_d    = {dst_addr_i[31:2], 2'b00};
        shift_d  = shift_i;
        remain_d = n_words;
        irq_d    = 1'b0;
        state_d  = (n_words == '0) ? DONE : RD_REQ;
      end
      RD_REQ: state_d = avm.waitrequest ? RD_REQ : RD_WAIT;
      RD_WAIT: if (avm.readdatavalid) begin
        pack_d   = half_q ? {q_hi, q_lo, pack_q[15:0]} : {16'h0, q_hi, q_lo};
        half_d   = !half_q;
        src_d    = src_q + 32'd4;
        remain_d = remain_q - CW'(1);
        state_d  = (half_q || remain_q == CW'(1)) ? WR : RD_REQ;
      end
      WR: if (!avm.waitrequest) begin
        dst_d   = dst_q + 32'd4;
        pack_d  = '0;
        half_d  = 1'b0;
        state_d = (remain_q != '0) ? RD_REQ : DONE;
      end
      DONE: begin
        irq_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; reset drops any half-built word and the completion flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      pack_q   <= '0;
      remain_q <= '0;
      shift_q  <= '0;
      half_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      pack_q   <= pack_d;
      remain_q <= remain_d;
      shift_q  <= shift_d;
      half_q   <= half_d;
      irq_q    <= irq_d;
    end
  end
endmodule

// File: tb/tb_normalizer_quantizer.sv
// tb_normalizer_quantizer: directed runs against a memory slave with stalls and variable read latency
module tb_normalizer_quantizer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_s = '0, src_e = '0, dst = '0;
  logic [3:0]  shift = '0;
  logic        busy, irq;
  normalizer_quantizer_if bus();
  normalizer_quantizer dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .src_start_addr_i(src_s),
    .src_stop_addr_i(src_e), .dst_addr_i(dst), .shift_i(shift),
    .busy_o(busy), .irq_o(irq), .avm(bus)
  );
  always #5 clk = ~clk;

  int          checks = 0, errors = 0, reads = 0, act = 0, stall_err = 0, lat_cnt = 0;
  bit          stall_en = 0, lat_rand = 0, held = 0;
  logic [65:0] hold_v;
  logic [31:0] pend;
  logic [31:0] mem [4096];
  logic [31:0] wq[$], aq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] q8(input logic [15:0] s, input logic [3:0] sh);
    logic [15:0] v;
    v = s >> sh;
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

  // memory slave: random stalls, read latency 1..8, stray readdatavalid, stall-stability monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      lat_cnt = 0;
      held = 0;
      bus.waitrequest = 1'b0;
      bus.readdatavalid = 1'b0;
      bus.readdata = '0;
    end else begin
      if (held && {bus.read, bus.write, bus.address, bus.writedata} !== hold_v) stall_err++;
      bus.readdatavalid = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus.readdatavalid = 1'b1;
          bus.readdata = pend;
        end
      end else if (stall_en && $urandom_range(0, 3) == 0) begin
        bus.readdatavalid = 1'b1;
        bus.readdata = 32'hDEADBEEF;
      end
      if (bus.read || bus.write) act++;
      bus.waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      held = (bus.read || bus.write) && bus.waitrequest;
      hold_v = {bus.read, bus.write, bus.address, bus.writedata};
      if (bus.read && !bus.waitrequest) begin
        pend = mem[bus.address[13:2]];
        lat_cnt = lat_rand ? int'($urandom_range(1, 8)) : 1;
        reads++;
      end
      if (bus.write && !bus.waitrequest) begin
        wq.push_back(bus.writedata);
        aq.push_back(bus.address);
      end
    end
  end

  task automatic run(input logic [31:0] s, e, d, input logic [3:0] sh, input int again,
                     input int budget, output int cyc, output logic b1);
    wq.delete();
    aq.delete();
    reads = 0;
    act = 0;
    stall_err = 0;
    src_s = s;
    src_e = e;
    dst = d;
    shift = sh;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    b1 = busy;
    while (!irq && cyc < budget) begin
      if (cyc == again) begin
        start = 1'b1;
        src_s = 32'h300;
        src_e = 32'h400;
        dst = 32'h0;
        shift = 4'd7;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check("irq_timeout", irq, 1);
    @(negedge clk);
  endtask

  task automatic cmp_writes(input string tag, input logic [31:0] exp[$], input logic [31:0] a0);
    check({tag, "_nwr"}, wq.size(), exp.size());
    foreach (exp[i]) begin
      check({tag, "_data"}, i < wq.size() ? wq[i] : 32'hx, exp[i]);
      check({tag, "_addr"}, i < aq.size() ? aq[i] : 32'hx, a0 + 32'(4 * i));
    end
  endtask

  initial begin
    int          cyc;
    logic        b1;
    logic [31:0] e1[$], e2[$], e6[$];
    e1.push_back(32'hFF000401);
    e2.push_back(32'h04030201);
    e2.push_back(32'h00000605);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_irq", irq, 0);
    check("rst_rw", {bus.read, bus.write}, 0);
    check("rst_addr", bus.address, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run(32'h300, 32'h300, 32'h1000, 4'd0, 0, 20, cyc, b1);
    check("t3_eq_cycles", cyc, 1);
    check("t3_eq_traffic", act, 0);
    run(32'h400, 32'h300, 32'h1000, 4'd0, 0, 20, cyc, b1);
    check("t3_lt_cycles", cyc, 1);
    check("t3_lt_traffic", act, 0);
    mem[12'h040] = 32'h00400010;
    mem[12'h041] = 32'h7FFF0000;
    run(32'h100, 32'h108, 32'h1000, 4'd4, 0, 100, cyc, b1);
    check("t1_cycles", cyc, 6);
    check("t1_busy", b1, 1);
    check("t1_reads", reads, 2);
    cmp_writes("t1", e1, 32'h1000);
    check("t1_idle_busy", busy, 0);
    check("t1_irq_sticky", irq, 1);
    mem[12'h080] = 32'h00020001;
    mem[12'h081] = 32'h00040003;
    mem[12'h082] = 32'h00060005;
    run(32'h200, 32'h20C, 32'h2000, 4'd0, 0, 100, cyc, b1);
    check("t2_cycles", cyc, 9);
    check("t2_reads", reads, 3);
    cmp_writes("t2", e2, 32'h2000);
    stall_en = 1;
    run(32'h203, 32'h20C, 32'hFFFFFFFF, 4'd0, 0, 400, cyc, b1);
    check("t4_reads", reads, 3);
    check("t4_stable", stall_err, 0);
    cmp_writes("t4", e2, 32'hFFFFFFFC);
    stall_en = 0;
    run(32'h200, 32'h20C, 32'h2000, 4'd0, 3, 100, cyc, b1);
    check("t5_restart_cycles", cyc, 9);
    cmp_writes("t5_restart", e2, 32'h2000);
    src_s = 32'h200;
    src_e = 32'h20C;
    dst = 32'h2000;
    shift = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!bus.write && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_reach_wr", bus.write, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_rw", {bus.read, bus.write}, 0);
    check("t5_rst_irq", irq, 0);
    check("t5_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(32'h200, 32'h20C, 32'h2000, 4'd0, 0, 100, cyc, b1);
    check("t5_after_cycles", cyc, 9);
    cmp_writes("t5_after", e2, 32'h2000);
    lat_rand = 1;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    for (int k = 0; k < 2048; k++)
      e6.push_back({q8(mem[2*k+1][31:16], 4'd3), q8(mem[2*k+1][15:0], 4'd3),
                    q8(mem[2*k][31:16], 4'd3), q8(mem[2*k][15:0], 4'd3)});
    run(32'h0, 32'h5000, 32'h8000, 4'd3, 0, 60000, cyc, b1);
    check("t6_reads", reads, 4096);
    cmp_writes("t6", e6, 32'h8000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
